button_conditioner: RTL and testbench

- Upstream front end for the stopwatch control logic. Takes raw, active-low, bouncing push-button inputs (start_stop, hold) and produces clean one-cycle press events plus debounced levels and long-press events.
- Sits between the board KEY pins and the stopwatch control block.
- Runs in the 50 MHz domain.
- Its long-press and auto-repeat pulses drive time adjustment in adjust mode.

---
 rtl/button_pkg.sv | 28 ++
 rtl/btn_channel.sv | 149 ++++++++++++++
 rtl/button_conditioner.sv | 38 +++
 tb/tb_button_conditioner.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM states,
// default cycle counts for a 50 MHz clock, and the counter-width helper.
package button_pkg;

  // Per-channel debounce / long-press state
  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    LONG,
    RELEASE_DB
  } btn_state_t;

  // Defaults for a 50 MHz clock
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms
  localparam int DEF_LONG_CYCLES     = 50_000_000; // 1 s
  localparam int DEF_REPEAT_CYCLES   = 5_000_000;  // 100 ms

  // Width of a counter that must reach (largest count - 1)
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: 2-flop synchroniser, debounce / long-press FSM
// and its shared counter.
// Optional feature: define BTN_AUTOREPEAT_EN to make long_pulse repeat every
// REPEAT_CYCLES while the button stays held after a long press.
module btn_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic CLK_50MHz,
  input  logic reset,
  input  logic btn_n_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LNG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             sync_1;
  logic             sync_2;
  logic             p;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             from_long;

  // Bring the asynchronous raw pin into the clock domain; idles released (1)
  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= btn_n_raw;
      sync_2 <= sync_1;
    end
  end

  // Active-high "pressed" view of the synchronised pin
  assign p = ~sync_2;

  // Debounce / long-press FSM with registered pulse and level outputs.
  // The cycle that moves into a debounce state already counts as the first
  // stable sample, so the counter starts at 1 there; a change is accepted on
  // the DEBOUNCE_CYCLES-th consecutive stable sample.
  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      from_long     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      // Level follows the accepted state one edge later
      btn_level     <= (state == PRESSED) || (state == LONG) || (state == RELEASE_DB);

      case (state)
        IDLE: begin
          cnt <= '0;
          if (p) begin
            state <= PRESS_DB;
            cnt   <= CNT_ONE;
          end
        end

        PRESS_DB: begin
          if (!p) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= DEB_LAST) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESSED: begin
          if (!p) begin
            state     <= RELEASE_DB;
            from_long <= 1'b0;
            cnt       <= CNT_ONE;
          end else if (cnt >= LNG_LAST) begin
            state      <= LONG;
            long_pulse <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        LONG: begin
          if (!p) begin
            state     <= RELEASE_DB;
            from_long <= 1'b1;
            cnt       <= CNT_ONE;
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (cnt >= REP_LAST) begin
              long_pulse <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
`else
            // Terminal hold: nothing more fires until release
            cnt <= '0;
`endif
          end
        end

        RELEASE_DB: begin
          if (p) begin
            // Release bounce: resume where we were, long/repeat timing restarts
            state <= from_long ? LONG : PRESSED;
            cnt   <= '0;
          end else if (cnt >= DEB_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the stopwatch: NUM_BTN independent channels of
// synchronise + debounce + press/release/long-press event generation.
// Optional feature: define BTN_AUTOREPEAT_EN for auto-repeating long_pulse.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic               CLK_50MHz,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse
);

  // Channels share nothing, so no arbitration is needed between them
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_chan (
      .CLK_50MHz    (CLK_50MHz),
      .reset        (reset),
      .btn_n_raw    (btn_n_raw[gi]),
      .btn_level    (btn_level[gi]),
      .press_pulse  (press_pulse[gi]),
      .release_pulse(release_pulse[gi]),
      .long_pulse   (long_pulse[gi])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short cycle counts (debounce 8, long 40,
// repeat 10). Inputs change #1 after a rising edge and outputs are sampled
// there too, so "tick c" means the state just after the c-th edge that saw
// the new raw value.
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int NB    = 2;
  localparam int DEB   = 8;
  localparam int LONGC = 40;
  localparam int REP   = 10;

  logic          CLK_50MHz = 1'b0;
  logic          reset     = 1'b0;
  logic [NB-1:0] btn_n_raw = 2'b11;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [NB-1:0] long_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 CLK_50MHz = ~CLK_50MHz;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONGC),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .CLK_50MHz    (CLK_50MHz),
    .reset        (reset),
    .btn_n_raw    (btn_n_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  function automatic logic [7:0] dut_vec();
    return {btn_level, press_pulse, release_pulse, long_pulse};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on run lengths: a change is accepted after DEB consecutive samples
  // that differ from the accepted level; long/repeat pulses are timed from an
  // anchor (acceptance, a recovered release bounce, or the previous pulse).
  logic [1:0]  m_hist1, m_hist2;
  int unsigned m_run[NB];
  int unsigned m_since[NB];
  logic        m_level[NB];
  logic        m_anchor[NB];
  logic        m_long_done[NB];
  logic [7:0]  m_exp;

  task automatic model_reset();
    m_hist1 = 2'b11;
    m_hist2 = 2'b11;
    for (int c = 0; c < NB; c++) begin
      m_run[c]       = 0;
      m_since[c]     = 0;
      m_level[c]     = 1'b0;
      m_anchor[c]    = 1'b0;
      m_long_done[c] = 1'b0;
    end
    m_exp = 8'h00;
  endtask

  task automatic model_step(input logic [1:0] raw);
    logic [1:0] pv, lvl_o, prs, rel, lng;
    pv      = ~m_hist2;        // pin value two edges ago, made active-high
    m_hist2 = m_hist1;
    m_hist1 = raw;
    for (int c = 0; c < NB; c++) begin
      lvl_o[c] = m_level[c];
      prs[c]   = 1'b0;
      rel[c]   = 1'b0;
      lng[c]   = 1'b0;
      if (pv[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_level[c] = pv[c];
          m_run[c]   = 0;
          if (pv[c]) begin
            prs[c]         = 1'b1;
            m_anchor[c]    = 1'b1;
            m_since[c]     = 0;
            m_long_done[c] = 1'b0;
          end else begin
            rel[c] = 1'b1;
          end
        end else if (m_level[c]) begin
          m_anchor[c] = 1'b0;   // held button dipped: hold timing broken
        end
      end else begin
        m_run[c] = 0;
        if (m_level[c]) begin
          if (!m_anchor[c]) begin
            m_anchor[c] = 1'b1;
            m_since[c]  = 0;
          end else begin
            m_since[c]++;
            if (!m_long_done[c]) begin
              if (m_since[c] == LONGC) begin
                lng[c]         = 1'b1;
                m_long_done[c] = 1'b1;
                m_since[c]     = 0;
              end
            end else begin
`ifdef BTN_AUTOREPEAT_EN
              if (m_since[c] == REP) begin
                lng[c]     = 1'b1;
                m_since[c] = 0;
              end
`endif
            end
          end
        end
      end
    end
    m_exp = {lvl_o, prs, rel, lng};
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [1:0] raw);
    btn_n_raw = raw;
    @(posedge CLK_50MHz);
    #1;
    model_step(raw);
  endtask

  task automatic do_reset(input logic [1:0] raw);
    btn_n_raw = raw;
    reset     = 1'b1;
    #1;
    check("reset_async", 32'(dut_vec()), 32'h0);
    repeat (3) begin
      @(posedge CLK_50MHz);
      #1;
      check("reset_hold", 32'(dut_vec()), 32'h0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- table of segments ----------------
  typedef struct {
    string      name;
    logic [1:0] raw;
    int         cycles;
    logic [1:0] exp_press;
    logic [1:0] exp_rel;
    logic [1:0] exp_long;
    logic [1:0] exp_level;
  } seg_t;

  seg_t segs[10];

  initial begin
    logic [1:0] acc_p, acc_r, acc_l;
    logic       exp_l;
    int         n_rel, rel_at, noise;
    int         seg_left[NB];
    logic [1:0] cur;
    logic [7:0] expv;

    segs[0] = '{"idle",         2'b11,  5, 2'b00, 2'b00, 2'b00, 2'b00};
    segs[1] = '{"b0_press",     2'b10, 20, 2'b01, 2'b00, 2'b00, 2'b01};
    segs[2] = '{"b0_release",   2'b11, 20, 2'b00, 2'b01, 2'b00, 2'b00};
    segs[3] = '{"b1_short",     2'b01,  5, 2'b00, 2'b00, 2'b00, 2'b00};
    segs[4] = '{"b1_short_end", 2'b11,  5, 2'b00, 2'b00, 2'b00, 2'b00};
    segs[5] = '{"both_press",   2'b00, 20, 2'b11, 2'b00, 2'b00, 2'b11};
    segs[6] = '{"b1_rel_glitch",2'b10,  5, 2'b00, 2'b00, 2'b00, 2'b11};
    segs[7] = '{"both_release", 2'b11, 20, 2'b00, 2'b11, 2'b00, 2'b00};
    segs[8] = '{"b0_long",      2'b10, 60, 2'b01, 2'b00, 2'b01, 2'b01};
    segs[9] = '{"b0_long_rel",  2'b11, 20, 2'b00, 2'b01, 2'b00, 2'b00};

    #2;
    do_reset(2'b11);

    // Table-driven segments
    foreach (segs[i]) begin
      acc_p = '0; acc_r = '0; acc_l = '0;
      for (int c = 0; c < segs[i].cycles; c++) begin
        tick(segs[i].raw);
        acc_p |= press_pulse;
        acc_r |= release_pulse;
        acc_l |= long_pulse;
      end
      check({segs[i].name, "_press"},   32'(acc_p),     32'(segs[i].exp_press));
      check({segs[i].name, "_release"}, 32'(acc_r),     32'(segs[i].exp_rel));
      check({segs[i].name, "_long"},    32'(acc_l),     32'(segs[i].exp_long));
      check({segs[i].name, "_level"},   32'(btn_level), 32'(segs[i].exp_level));
    end

    // Clean press on btn0: press at 10, level from 11, long at 50 (+repeats)
    do_reset(2'b11);
    for (int c = 1; c <= 110; c++) begin
      tick(2'b10);
`ifdef BTN_AUTOREPEAT_EN
      exp_l = (c >= 50) && ((c - 50) % REP == 0);
`else
      exp_l = (c == 50);
`endif
      check("clean_press",   32'(press_pulse),   32'({1'b0, c == 10}));
      check("clean_level",   32'(btn_level),     32'({1'b0, c >= 11}));
      check("clean_long",    32'(long_pulse),    32'({1'b0, exp_l}));
      check("clean_release", 32'(release_pulse), 32'h0);
    end
    for (int c = 1; c <= 20; c++) begin
      tick(2'b11);
      check("clean_rel_pulse", 32'(release_pulse), 32'({1'b0, c == 10}));
      check("clean_rel_level", 32'(btn_level),     32'({1'b0, c <= 10}));
      check("clean_rel_quiet", 32'({press_pulse, long_pulse}), 32'h0);
    end

    // Bounce on btn1: toggling every 3 cycles never qualifies
    do_reset(2'b11);
    for (int c = 1; c <= 50; c++) begin
      if (c <= 30) tick({(((c - 1) / 3) % 2 == 1), 1'b1});
      else         tick(2'b11);
      check("bounce_quiet", 32'(dut_vec()), 32'h0);
    end

    // Release with 4 bounces of 2 cycles on btn0
    do_reset(2'b11);
    for (int c = 1; c <= 20; c++) tick(2'b10);
    check("relb_held", 32'(btn_level), 32'h1);
    noise = 0;
    for (int k = 0; k < 4; k++) begin
      repeat (2) begin tick(2'b11); noise += int'(release_pulse[0]) + int'(press_pulse[0]); end
      repeat (2) begin tick(2'b10); noise += int'(release_pulse[0]) + int'(press_pulse[0]); end
    end
    check("relb_no_early_pulse", 32'(noise), 32'h0);
    n_rel = 0; rel_at = -1;
    for (int c = 1; c <= 20; c++) begin
      tick(2'b11);
      if (release_pulse[0]) begin n_rel++; rel_at = c; end
    end
    check("relb_count",   32'(n_rel),     32'h1);
    check("relb_latency", 32'(rel_at),    32'(2 + DEB));
    check("relb_level",   32'(btn_level), 32'h0);

    // Both buttons in the same cycle
    do_reset(2'b11);
    for (int c = 1; c <= 20; c++) begin
      tick(2'b00);
      check("both_press", 32'(press_pulse), (c == 10) ? 32'h3 : 32'h0);
    end

    // Reset while PRESSED, button still held afterwards
    do_reset(2'b00);
    for (int c = 1; c <= 12; c++) begin
      tick(2'b00);
      check("post_reset_press", 32'(press_pulse), (c == 10) ? 32'h3 : 32'h0);
      check("post_reset_level", 32'(btn_level),   (c >= 11) ? 32'h3 : 32'h0);
    end

    // Randomized segments against the reference model
    do_reset(2'b11);
    seg_left[0] = 0; seg_left[1] = 0;
    cur = 2'b11;
    for (int i = 0; i < 4000; i++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (seg_left[ch] == 0) begin
          cur[ch]      = 1'($urandom_range(0, 1));
          seg_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                     : int'($urandom_range(5, 70));
        end
        seg_left[ch]--;
      end
      tick(cur);
      exp_q.push_back(m_exp);
      expv = exp_q.pop_front();
      check("random", 32'(dut_vec()), 32'(expv));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
